// File: rtl/bomb_pkg.sv
// Shared bomb-slot types, board geometry and blast-cross helper used by the
// scheduler, the object store and the renderer.
package bomb_pkg;

  localparam int          ROWS       = 11;
  localparam int          COLUMNS    = 17;
  localparam int          TILE_ORDER = 5;
  localparam logic [10:0] X_MATRIX   = 11'h020;
  localparam logic [10:0] Y_MATRIX   = 11'h060;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BLAST = 2'd2
  } slot_state_t;

  typedef struct packed {
    slot_state_t state;
    logic [3:0]  row;
    logic [4:0]  col;
    logic [7:0]  timer;
  } slot_t;

  // Tile (r,c) lies on the cross of a bomb at (br,bc); arms are unbounded by
  // walls and naturally clipped because tile coordinates are never negative.
  function automatic logic in_cross(input logic [3:0] r, input logic [4:0] c,
                                    input logic [3:0] br, input logic [4:0] bc,
                                    input logic [5:0] radius);
    logic signed [5:0] dr;
    logic signed [5:0] dc;
    logic [5:0]        adr;
    logic [5:0]        adc;
    dr  = $signed({2'b00, r}) - $signed({2'b00, br});
    dc  = $signed({1'b0, c}) - $signed({1'b0, bc});
    adr = dr[5] ? 6'(-dr) : 6'(dr);
    adc = dc[5] ? 6'(-dc) : 6'(dc);
    return ((r == br) && (adc <= radius)) || ((c == bc) && (adr <= radius));
  endfunction

endpackage

// File: rtl/bomb_scheduler_if.sv
// Drop-request handshake between the player controller and the bomb scheduler.
interface bomb_scheduler_if;
  logic       drop_req;
  logic [3:0] drop_row;
  logic [4:0] drop_col;
  logic       drop_ack;
  logic       drop_nack;

  modport master (output drop_req, drop_row, drop_col, input drop_ack, drop_nack);
  modport slave  (input drop_req, drop_row, drop_col, output drop_ack, drop_nack);
endinterface

// File: rtl/bomb_scheduler_tile_locator.sv
// Maps a scan position to board tile coordinates; pixels left of or above the
// board wrap to large values after subtraction and are rejected explicitly.
module tile_locator #(
  parameter logic [10:0] X_MATRIX   = bomb_pkg::X_MATRIX,
  parameter logic [10:0] Y_MATRIX   = bomb_pkg::Y_MATRIX,
  parameter int          TILE_ORDER = bomb_pkg::TILE_ORDER,
  parameter int          ROWS       = bomb_pkg::ROWS,
  parameter int          COLUMNS    = bomb_pkg::COLUMNS
) (
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic        on_board,
  output logic [3:0]  tile_row,
  output logic [4:0]  tile_col
);

  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] col_full;
  logic [10:0] row_full;

  assign dx       = pixel_x - X_MATRIX;
  assign dy       = pixel_y - Y_MATRIX;
  assign col_full = dx >> TILE_ORDER;
  assign row_full = dy >> TILE_ORDER;

  assign on_board = (pixel_x >= X_MATRIX) && (pixel_y >= Y_MATRIX) &&
                    (col_full < 11'(COLUMNS)) && (row_full < 11'(ROWS));
  assign tile_col = col_full[4:0];
  assign tile_row = row_full[3:0];

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb lifecycle owner: drop arbitration, per-slot fuse/blast timers with chain
// reactions, and registered per-pixel explosion / bomb-draw indications.
module bomb_scheduler #(
  parameter int          NUM_BOMBS    = 4,
  parameter int          FUSE_FRAMES  = 120,
  parameter int          BLAST_FRAMES = 30,
  parameter int          BLAST_RADIUS = 2,
  parameter logic [10:0] X_MATRIX     = bomb_pkg::X_MATRIX,
  parameter logic [10:0] Y_MATRIX     = bomb_pkg::Y_MATRIX,
  parameter int          TILE_ORDER   = bomb_pkg::TILE_ORDER,
  parameter int          ROWS         = bomb_pkg::ROWS,
  parameter int          COLUMNS      = bomb_pkg::COLUMNS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_of_frame,
  input  logic [10:0]            pixel_x,
  input  logic [10:0]            pixel_y,
  bomb_scheduler_if.slave        drop_if,
  output logic                   explosion,
  output logic                   bomb_pixel,
  output logic [3:0]             active_count
);

  import bomb_pkg::*;

  localparam logic [5:0] RADIUS = 6'(BLAST_RADIUS);
  localparam logic [7:0] FUSE   = 8'(FUSE_FRAMES);
  localparam logic [7:0] BURN   = 8'(BLAST_FRAMES);

  slot_t      slots      [NUM_BOMBS];
  slot_t      slots_next [NUM_BOMBS];
  logic       accept;
  logic [3:0] next_count;
  logic       on_board;
  logic [3:0] tile_row;
  logic [4:0] tile_col;
  logic       explosion_d;
  logic       bomb_pixel_d;

  tile_locator #(
    .X_MATRIX  (X_MATRIX),
    .Y_MATRIX  (Y_MATRIX),
    .TILE_ORDER(TILE_ORDER),
    .ROWS      (ROWS),
    .COLUMNS   (COLUMNS)
  ) u_tile_locator (
    .pixel_x (pixel_x),
    .pixel_y (pixel_y),
    .on_board(on_board),
    .tile_row(tile_row),
    .tile_col(tile_col)
  );

  // Drop arbitration and the frame tick both look only at pre-edge slot
  // values, so a slot finishing its blast this tick is not yet free.
  always_comb begin
    logic tile_ok;
    logic occupied;
    logic free_found;
    logic chained;
    logic loaded;
    // NOTE: every combinational output gets a default up front so no path
    // leaves it unassigned, which would otherwise infer a latch.
    slots_next = slots;
    next_count = '0;
    tile_ok    = (drop_if.drop_row < 4'(ROWS)) && (drop_if.drop_col < 5'(COLUMNS));
    occupied   = 1'b0;
    free_found = 1'b0;
    chained    = 1'b0;
    loaded     = 1'b0;

    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (slots[i].state != IDLE && slots[i].row == drop_if.drop_row &&
          slots[i].col == drop_if.drop_col)
        occupied = 1'b1;
      if (slots[i].state == IDLE)
        free_found = 1'b1;
    end
    accept = drop_if.drop_req && tile_ok && !occupied && free_found;

    if (start_of_frame) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        chained = 1'b0;
        for (int j = 0; j < NUM_BOMBS; j++)
          if (slots[j].state == BLAST &&
              in_cross(slots[i].row, slots[i].col, slots[j].row, slots[j].col, RADIUS))
            chained = 1'b1;
        case (slots[i].state)
          ARMED: begin
            if (slots[i].timer == 8'd1 || chained) begin
              slots_next[i].state = BLAST;
              slots_next[i].timer = BURN;
            end else begin
              slots_next[i].timer = slots[i].timer - 8'd1;
            end
          end
          BLAST: begin
            if (slots[i].timer == 8'd1) begin
              slots_next[i].state = IDLE;
              slots_next[i].timer = '0;
            end else begin
              slots_next[i].timer = slots[i].timer - 8'd1;
            end
          end
          default: ;
        endcase
      end
    end

    // The chosen slot was IDLE before the edge, so the tick never touches it
    // and the fresh fuse starts undecremented.
    if (accept) begin
      for (int i = 0; i < NUM_BOMBS; i++) begin
        if (!loaded && slots[i].state == IDLE) begin
          slots_next[i] = '{state: ARMED, row: drop_if.drop_row,
                            col: drop_if.drop_col, timer: FUSE};
          loaded = 1'b1;
        end
      end
    end

    for (int i = 0; i < NUM_BOMBS; i++)
      if (slots_next[i].state != IDLE)
        next_count = next_count + 4'd1;
  end

  always_comb begin
    explosion_d  = 1'b0;
    bomb_pixel_d = 1'b0;
    for (int i = 0; i < NUM_BOMBS; i++) begin
      if (on_board && slots[i].state == BLAST &&
          in_cross(tile_row, tile_col, slots[i].row, slots[i].col, RADIUS))
        explosion_d = 1'b1;
      if (on_board && slots[i].state == ARMED &&
          slots[i].row == tile_row && slots[i].col == tile_col)
        bomb_pixel_d = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BOMBS; i++)
        slots[i] <= '{state: IDLE, row: '0, col: '0, timer: '0};
      drop_if.drop_ack  <= 1'b0;
      drop_if.drop_nack <= 1'b0;
      explosion         <= 1'b0;
      bomb_pixel        <= 1'b0;
      active_count      <= '0;
    end else begin
      slots             <= slots_next;
      drop_if.drop_ack  <= accept;
      drop_if.drop_nack <= drop_if.drop_req && !accept;
      explosion         <= explosion_d;
      bomb_pixel        <= bomb_pixel_d;
      active_count      <= next_count;
    end
  end

endmodule

// File: tb/tb_bomb_scheduler.sv
// Directed bench for bomb_scheduler with short fuse/blast timers so every
// lifecycle phase is reachable within a few frame ticks.
module tb_bomb_scheduler;
  import bomb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        sof;
  logic [10:0] px;
  logic [10:0] py;
  logic        explosion;
  logic        bomb_pixel;
  logic [3:0]  active_count;

  int n_checks = 0;
  int n_fail   = 0;

  bomb_scheduler_if drop_if ();

  bomb_scheduler #(
    .NUM_BOMBS   (4),
    .FUSE_FRAMES (3),
    .BLAST_FRAMES(2),
    .BLAST_RADIUS(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_of_frame(sof),
    .pixel_x       (px),
    .pixel_y       (py),
    .drop_if       (drop_if),
    .explosion     (explosion),
    .bomb_pixel    (bomb_pixel),
    .active_count  (active_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drop(input logic [3:0] r, input logic [4:0] c, input logic ack_exp,
                      input logic with_tick, input string tag);
    @(negedge clk);
    drop_if.drop_req = 1'b1;
    drop_if.drop_row = r;
    drop_if.drop_col = c;
    sof              = with_tick;
    @(posedge clk);
    #1;
    drop_if.drop_req = 1'b0;
    sof              = 1'b0;
    check({tag, "_ack"},  32'(drop_if.drop_ack),  32'(ack_exp));
    check({tag, "_nack"}, 32'(drop_if.drop_nack), 32'(!ack_exp));
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sof = 1'b1;
      @(posedge clk);
      #1;
      sof = 1'b0;
    end
  endtask

  task automatic probe_px(input logic [10:0] x, input logic [10:0] y,
                          input logic exp_expl, input logic exp_bomb, input string tag);
    @(negedge clk);
    px = x;
    py = y;
    @(posedge clk);
    #1;
    check({tag, "_expl"}, 32'(explosion),  32'(exp_expl));
    check({tag, "_bomb"}, 32'(bomb_pixel), 32'(exp_bomb));
  endtask

  task automatic probe(input int r, input int c, input logic exp_expl,
                       input logic exp_bomb, input string tag);
    probe_px(11'(32 + c * 32 + 16), 11'(96 + r * 32 + 16), exp_expl, exp_bomb, tag);
  endtask

  initial begin
    rst = 1'b1;
    sof = 1'b0;
    px  = '0;
    py  = '0;
    drop_if.drop_req = 1'b0;
    drop_if.drop_row = '0;
    drop_if.drop_col = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack",    32'(drop_if.drop_ack),  32'd0);
    check("rst_nack",   32'(drop_if.drop_nack), 32'd0);
    check("rst_expl",   32'(explosion),         32'd0);
    check("rst_bomb",   32'(bomb_pixel),        32'd0);
    check("rst_active", 32'(active_count),      32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single bomb lifecycle at (4,6): pixels 224..255 on both axes.
    drop(4, 6, 1'b1, 1'b0, "life_drop");
    check("life_active1", 32'(active_count), 32'd1);
    @(posedge clk);
    #1;
    check("life_ack_pulse", 32'(drop_if.drop_ack), 32'd0);
    probe_px(11'd224, 11'd224, 1'b0, 1'b1, "life_tl");
    probe_px(11'd255, 11'd255, 1'b0, 1'b1, "life_br");
    probe_px(11'd256, 11'd224, 1'b0, 1'b0, "life_right");
    probe_px(11'd223, 11'd224, 1'b0, 1'b0, "life_left");
    @(negedge clk);
    px = 11'd230;
    py = 11'd230;
    @(posedge clk);
    #1;
    px = 11'd300;
    @(negedge clk);
    check("life_lag_hold", 32'(bomb_pixel), 32'd1);
    @(posedge clk);
    #1;
    check("life_lag_drop", 32'(bomb_pixel), 32'd0);
    tick(2);
    probe(4, 6, 1'b0, 1'b1, "life_tick2");
    tick(1);
    probe(4, 6, 1'b1, 1'b0, "life_blast");
    probe(4, 8, 1'b1, 1'b0, "life_arm_r");
    probe(2, 6, 1'b1, 1'b0, "life_arm_u");
    probe(4, 9, 1'b0, 1'b0, "life_out_r");
    probe(5, 7, 1'b0, 1'b0, "life_diag");
    check("life_active_blast", 32'(active_count), 32'd1);
    tick(1);
    probe(4, 6, 1'b1, 1'b0, "life_tick4");
    tick(1);
    probe(4, 6, 1'b0, 1'b0, "life_idle");
    check("life_active0", 32'(active_count), 32'd0);

    // Capacity, occupancy and range rejection.
    drop(0, 0, 1'b1, 1'b0, "cap_d0");
    drop(11, 0, 1'b0, 1'b0, "cap_row11");
    drop(0, 17, 1'b0, 1'b0, "cap_col17");
    drop(0, 1, 1'b1, 1'b0, "cap_d1");
    drop(0, 2, 1'b1, 1'b0, "cap_d2");
    drop(0, 1, 1'b0, 1'b0, "cap_occupied");
    check("cap_active3", 32'(active_count), 32'd3);
    drop(10, 16, 1'b1, 1'b0, "cap_corner");
    check("cap_active4", 32'(active_count), 32'd4);
    drop(1, 1, 1'b0, 1'b0, "cap_full");
    tick(5);
    check("cap_drained", 32'(active_count), 32'd0);

    // Cross shape and off-board handling for a blast at (0,0).
    drop(0, 0, 1'b1, 1'b0, "x_drop");
    tick(3);
    probe(0, 0, 1'b1, 1'b0, "x_00");
    probe(0, 1, 1'b1, 1'b0, "x_01");
    probe(0, 2, 1'b1, 1'b0, "x_02");
    probe(1, 0, 1'b1, 1'b0, "x_10");
    probe(2, 0, 1'b1, 1'b0, "x_20");
    probe(0, 3, 1'b0, 1'b0, "x_03");
    probe(1, 1, 1'b0, 1'b0, "x_11");
    probe(10, 0, 1'b0, 1'b0, "x_100");
    probe_px(11'd31, 11'd112, 1'b0, 1'b0, "x_left_edge");
    probe_px(11'd0, 11'd112, 1'b0, 1'b0, "x_left_zero");
    probe_px(11'd40, 11'd95, 1'b0, 1'b0, "x_above");
    tick(2);
    check("x_drained", 32'(active_count), 32'd0);

    // Chain reaction: A(2,2) blasting, B(2,4) in its cross, C(2,5) only in B's.
    drop(2, 2, 1'b1, 1'b0, "ch_a");
    tick(3);
    drop(2, 4, 1'b1, 1'b0, "ch_b");
    drop(2, 5, 1'b1, 1'b0, "ch_c");
    probe(2, 4, 1'b1, 1'b1, "ch_b_armed");
    probe(2, 5, 1'b0, 1'b1, "ch_c_armed");
    tick(1);
    probe(2, 4, 1'b1, 1'b0, "ch_b_blast");
    probe(2, 6, 1'b1, 1'b0, "ch_b_cross");
    probe(2, 5, 1'b1, 1'b1, "ch_c_still");
    probe(2, 7, 1'b0, 1'b0, "ch_c_quiet");
    check("ch_active3", 32'(active_count), 32'd3);
    tick(1);
    probe(2, 5, 1'b1, 1'b0, "ch_c_blast");
    probe(2, 7, 1'b1, 1'b0, "ch_c_cross");
    check("ch_active2", 32'(active_count), 32'd2);
    tick(2);
    check("ch_drained", 32'(active_count), 32'd0);

    // Drop coinciding with the tick that retires slot 0.
    drop(5, 5, 1'b1, 1'b0, "co_x");
    tick(3);
    drop(7, 7, 1'b1, 1'b0, "co_y");
    tick(1);
    drop(9, 9, 1'b1, 1'b1, "co_z");
    check("co_slot0_idle",  32'(dut.slots[0].state), 32'(IDLE));
    check("co_slot2_armed", 32'(dut.slots[2].state), 32'(ARMED));
    check("co_slot2_fuse",  32'(dut.slots[2].timer), 32'd3);
    check("co_slot1_timer", 32'(dut.slots[1].timer), 32'd1);
    check("co_active2",     32'(active_count),       32'd2);
    tick(1);
    probe(7, 7, 1'b1, 1'b0, "co_y_blast");
    tick(1);
    probe(9, 9, 1'b0, 1'b1, "co_z_armed");
    tick(1);
    probe(9, 9, 1'b1, 1'b0, "co_z_blast");
    tick(2);
    check("co_drained", 32'(active_count), 32'd0);

    // Reset during a blast.
    drop(3, 3, 1'b1, 1'b0, "rb_drop");
    tick(3);
    probe(3, 3, 1'b1, 1'b0, "rb_blast");
    @(negedge clk);
    rst = 1'b1;
    drop_if.drop_req = 1'b1;
    drop_if.drop_row = 4'd6;
    drop_if.drop_col = 5'd6;
    @(posedge clk);
    #1;
    check("rb_expl",   32'(explosion),         32'd0);
    check("rb_active", 32'(active_count),      32'd0);
    check("rb_ack",    32'(drop_if.drop_ack),  32'd0);
    check("rb_nack",   32'(drop_if.drop_nack), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drop_if.drop_req = 1'b0;
    drop(3, 3, 1'b1, 1'b0, "rb_redrop");
    check("rb_slot0", 32'(dut.slots[0].state), 32'(ARMED));
    check("rb_slot0_row", 32'(dut.slots[0].row), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
